ula_multiciclo: RTL and testbench

//  Multi-cycle, width-parametrised ALU for the processor datapath.

---
 rtl/ula_multiciclo_pkg.sv | 37 +++
 rtl/ula_multdiv_iter.sv | 87 ++++++++
 rtl/ula_multiciclo.sv | 140 ++++++++++++++
 tb/tb_ula_multiciclo.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/ula_multiciclo_pkg.sv
// Shared definitions for the multi-cycle ALU: operation codes, FSM states
// and the test that picks out operations handled by the iterative engine.
`default_nettype none

package ula_multiciclo_pkg;

  localparam logic [4:0] OP_AND  = 5'b00000;
  localparam logic [4:0] OP_OR   = 5'b00001;
  localparam logic [4:0] OP_ADD  = 5'b00010;
  localparam logic [4:0] OP_SRL  = 5'b00011;
  localparam logic [4:0] OP_MUL  = 5'b00100;
  localparam logic [4:0] OP_DIV  = 5'b00101;
  localparam logic [4:0] OP_SUB  = 5'b00110;
  localparam logic [4:0] OP_SLT  = 5'b00111;
  localparam logic [4:0] OP_LUI  = 5'b01000;
  localparam logic [4:0] OP_REM  = 5'b01001;
  localparam logic [4:0] OP_SGT  = 5'b01010;
  localparam logic [4:0] OP_SGTE = 5'b01011;
  localparam logic [4:0] OP_NOT  = 5'b01100;
  localparam logic [4:0] OP_SEQ  = 5'b01101;
  localparam logic [4:0] OP_SLL  = 5'b01110;
  localparam logic [4:0] OP_SNEQ = 5'b01111;
  localparam logic [4:0] OP_SLTE = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } ula_state_e;

  function automatic logic is_iter_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ula_multdiv_iter.sv
// Iterative engine: shift-add multiply (low WIDTH bits) and restoring divide,
// one bit per cycle for WIDTH cycles after load.
`default_nettype none

module ula_multdiv_iter
  import ula_multiciclo_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             is_div,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

  logic             run;
  logic             mode_div;
  logic [CW-1:0]    steps;
  // part: product accumulator / partial remainder
  // shreg: multiplicand shifting left / dividend shifting into quotient
  // oper: multiplier shifting right / divisor
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] oper;

  logic [WIDTH-1:0] part_n;
  logic [WIDTH-1:0] shreg_n;
  logic [WIDTH-1:0] oper_n;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  always_comb begin
    shifted = {part, shreg[WIDTH-1]};
    diff    = shifted - {1'b0, oper};
    fits    = ~diff[WIDTH];
    if (mode_div) begin
      part_n  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
      shreg_n = {shreg[WIDTH-2:0], fits};
      oper_n  = oper;
    end else begin
      part_n  = oper[0] ? (part + shreg) : part;
      shreg_n = shreg << 1;
      oper_n  = oper >> 1;
    end
  end

  // Outputs show the value after the iteration in progress, so the owner can
  // capture the final answer on the same edge that finishes the last step.
  assign result_lo = mode_div ? shreg_n : part_n;
  assign remainder = part_n;
  assign busy      = run;

  always_ff @(posedge clock) begin
    if (!reset) begin
      run      <= 1'b0;
      mode_div <= 1'b0;
      steps    <= '0;
      part     <= '0;
      shreg    <= '0;
      oper     <= '0;
    end else if (load) begin
      run      <= 1'b1;
      mode_div <= is_div;
      steps    <= CW'(WIDTH - 1);
      part     <= '0;
      shreg    <= A;
      oper     <= B;
    end else if (run) begin
      part  <= part_n;
      shreg <= shreg_n;
      oper  <= oper_n;
      steps <= steps - 1'b1;
      if (steps == '0) run <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ula_multiciclo.sv
// Multi-cycle ALU: single-cycle op mux plus iterative mul/div/rem behind a
// start/busy/done handshake; result and zero flag are registered.
`default_nettype none

module ula_multiciclo
  import ula_multiciclo_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int LUI_SHIFT = 18
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       ULActl,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] ULAout,
  output logic             zero,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int               CW          = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

  ula_state_e       state, state_n;
  logic [4:0]       op_r;
  logic [CW-1:0]    cnt, cnt_n;
  logic [WIDTH-1:0] res_n;
  logic             res_we;
  logic             dz_n;
  logic             load;
  logic [WIDTH-1:0] single_res;
  logic [WIDTH-1:0] eng_lo;
  logic [WIDTH-1:0] eng_rem;
  logic             eng_busy;

  ula_multdiv_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clock    (clock),
    .reset    (reset),
    .load     (load),
    .is_div   (ULActl != OP_MUL),
    .A        (A),
    .B        (B),
    .busy     (eng_busy),
    .result_lo(eng_lo),
    .remainder(eng_rem)
  );

  always_comb begin
    single_res = '0;
    case (ULActl)
      OP_AND:  single_res = A & B;
      OP_OR:   single_res = A | B;
      OP_ADD:  single_res = A + B;
      OP_SUB:  single_res = A - B;
      OP_SRL:  single_res = (B >= SHIFT_LIMIT) ? '0 : (A >> B);
      OP_SLL:  single_res = (B >= SHIFT_LIMIT) ? '0 : (A << B);
      OP_LUI:  single_res = B << LUI_SHIFT;
      OP_NOT:  single_res = ~A;
      OP_SLT:  single_res = WIDTH'(A <  B);
      OP_SGT:  single_res = WIDTH'(A >  B);
      OP_SGTE: single_res = WIDTH'(A >= B);
      OP_SLTE: single_res = WIDTH'(A <= B);
      OP_SEQ:  single_res = WIDTH'(A == B);
      OP_SNEQ: single_res = WIDTH'(A != B);
      default: single_res = '0;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    res_n   = ULAout;
    res_we  = 1'b0;
    dz_n    = div_zero;
    load    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          dz_n = 1'b0;
          if (!is_iter_op(ULActl)) begin
            res_n   = single_res;
            res_we  = 1'b1;
            state_n = ST_DONE;
          end else if ((ULActl != OP_MUL) && (B == '0)) begin
            // Division by zero never enters the engine.
            res_n   = (ULActl == OP_DIV) ? '1 : A;
            res_we  = 1'b1;
            dz_n    = 1'b1;
            state_n = ST_DONE;
          end else begin
            load    = 1'b1;
            cnt_n   = CW'(WIDTH - 1);
            state_n = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        cnt_n = cnt - 1'b1;
        if (cnt == '0) begin
          res_n   = (op_r == OP_REM) ? eng_rem : eng_lo;
          res_we  = 1'b1;
          state_n = ST_DONE;
        end
      end
      ST_DONE: state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      op_r     <= OP_AND;
      cnt      <= '0;
      ULAout   <= '0;
      zero     <= 1'b1;
      div_zero <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      div_zero <= dz_n;
      if (load) op_r <= ULActl;
      if (res_we) begin
        ULAout <= res_n;
        zero   <= (res_n == '0);
      end
    end
  end

  assign done = (state == ST_DONE);
  assign busy = eng_busy;

endmodule

`default_nettype wire

// File: tb/tb_ula_multiciclo.sv
// Directed self-checking bench for ula_multiciclo with hand-computed vectors.
`default_nettype none

module tb_ula_multiciclo;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  ULActl = 5'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic [31:0] ULAout;
  logic        zero, busy, done, div_zero;

  int checks = 0;
  int errors = 0;

  ula_multiciclo #(.WIDTH(32), .LUI_SHIFT(18)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .ULActl  (ULActl),
    .A       (A),
    .B       (B),
    .ULAout  (ULAout),
    .zero    (zero),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble inputs after accept, wait for done and check it all.
  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input logic exp_dz);
    int n;
    bit busy_ok;
    @(negedge clock);
    start = 1'b1; ULActl = op; A = a; B = b;
    @(negedge clock);
    start = 1'b0; ULActl = 5'($urandom); A = $urandom; B = $urandom;
    n = 1;
    busy_ok = 1'b1;
    while (!done && n < 100) begin
      if (!busy) busy_ok = 1'b0;
      @(negedge clock);
      n++;
    end
    check_val({tag, "_lat"}, n, exp_lat);
    check_val({tag, "_res"}, ULAout, exp_res);
    check_val({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_res == 32'd0});
    check_val({tag, "_dz"}, {31'd0, div_zero}, {31'd0, exp_dz});
    check_val({tag, "_busy"}, {31'd0, busy_ok && !busy}, 32'd1);
    @(negedge clock);
    check_val({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n;
    bit seen_done;

    repeat (3) @(negedge clock);
    check_val("rst_out", ULAout, 32'd0);
    check_val("rst_flags", {28'd0, zero, busy, done, div_zero}, 32'b1000);
    reset = 1'b1;

    run_op("add_wrap", 5'b00010, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b0);
    run_op("sub",      5'b00110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 1'b0);
    run_op("and",      5'b00000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1, 1'b0);
    run_op("or",       5'b00001, 32'hF000_0001, 32'h0000_0F00, 32'hF000_0F01, 1, 1'b0);
    run_op("mul",      5'b00100, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F, 33, 1'b0);
    run_op("div",      5'b00101, 32'd100, 32'd7, 32'd14, 33, 1'b0);
    run_op("rem",      5'b01001, 32'd100, 32'd7, 32'd2, 33, 1'b0);
    run_op("div0",     5'b00101, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b1);
    run_op("rem0",     5'b01001, 32'd5, 32'd0, 32'd5, 1, 1'b1);
    run_op("dz_clr",   5'b00010, 32'd2, 32'd3, 32'd5, 1, 1'b0);
    run_op("sll",      5'b01110, 32'd1, 32'd31, 32'h8000_0000, 1, 1'b0);
    run_op("srl32",    5'b00011, 32'hDEAD_BEEF, 32'd32, 32'd0, 1, 1'b0);
    run_op("srl4",     5'b00011, 32'hDEAD_BEEF, 32'd4, 32'h0DEA_DBEE, 1, 1'b0);
    run_op("lui",      5'b01000, 32'd0, 32'd3, 32'h000C_0000, 1, 1'b0);
    run_op("slte_eq",  5'b10000, 32'd4, 32'd4, 32'd1, 1, 1'b0);
    run_op("bad_code", 5'b10001, 32'd9, 32'd9, 32'd0, 1, 1'b0);
    run_op("seq",      5'b01101, 32'd7, 32'd7, 32'd1, 1, 1'b0);
    run_op("sneq",     5'b01111, 32'd7, 32'd7, 32'd0, 1, 1'b0);
    run_op("not",      5'b01100, 32'd0, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("slt_u",    5'b00111, 32'd1, 32'hFFFF_FFFF, 32'd1, 1, 1'b0);
    run_op("sgt",      5'b01010, 32'd3, 32'd9, 32'd0, 1, 1'b0);
    run_op("sgte",     5'b01011, 32'd9, 32'd9, 32'd1, 1, 1'b0);
    run_op("mul_big",  5'b00100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 33, 1'b0);
    run_op("div_big",  5'b00101, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33, 1'b0);
    run_op("rem_big",  5'b01001, 32'hFFFF_FFFF, 32'h10, 32'hF, 33, 1'b0);

    // start pulsed mid-multiply with a different op must be ignored
    @(negedge clock);
    start = 1'b1; ULActl = 5'b00100; A = 32'h0001_0003; B = 32'h0000_0005;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    start = 1'b1; ULActl = 5'b00010; A = 32'd1; B = 32'd1;
    @(negedge clock);
    start = 1'b0;
    n = 5;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    check_val("ign_lat", n, 33);
    check_val("ign_res", ULAout, 32'h0005_000F);
    @(negedge clock);

    // reset during CALC aborts with no done pulse
    @(negedge clock);
    start = 1'b1; ULActl = 5'b00100; A = 32'd6; B = 32'd7;
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    check_val("abort_out", ULAout, 32'd0);
    check_val("abort_flags", {29'd0, zero, busy, done}, 32'b100);
    seen_done = 1'b0;
    repeat (40) begin
      @(negedge clock);
      if (done || busy) seen_done = 1'b1;
    end
    check_val("abort_quiet", {31'd0, seen_done}, 32'd0);
    run_op("post_rst", 5'b00010, 32'd2, 32'd3, 32'd5, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
